// File: rtl/a2d_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | a2d_pkg : shared types and constants for the A2D sequencer           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    XMIT1  = 3'd1,
    GAP    = 3'd2,
    XMIT2  = 3'd3,
    UPDATE = 3'd4
  } a2d_state_t;

  localparam logic [2:0] CH_BATT   = 3'd0;
  localparam logic [2:0] CH_CURR   = 3'd1;
  localparam logic [2:0] CH_BRAKE  = 3'd3;
  localparam logic [2:0] CH_TORQUE = 3'd4;

  localparam int SCLK_DIV      = 32;
  localparam int PERIOD_W      = 14;
  localparam int PERIOD_W_FAST = 9;

  function automatic logic [2:0] idx2chnl(input logic [1:0] idx);
    case (idx)
      2'd0:    idx2chnl = CH_BATT;
      2'd1:    idx2chnl = CH_CURR;
      2'd2:    idx2chnl = CH_BRAKE;
      default: idx2chnl = CH_TORQUE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_intf_spi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_mnrch : 16-bit SPI master, SCLK = clk/SCLK_DIV, idle high        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_mnrch
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rspns,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam logic [DIV_W-1:0] c_FALL = DIV_W'(SCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] c_RISE = '1;

  logic             r_busy;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_bits;
  logic [15:0]      r_shft;
  logic             r_miso;
  logic             r_ss_n;
  logic             r_fin;
  logic             r_done;

  // SCLK is high for the first half period after SS_n falls, so the first
  // edge the slave sees is a fall; the "fall" slot after the 16th rise ends
  // the frame instead of toggling SCLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_div  <= '0;
      r_bits <= '0;
      r_shft <= '0;
      r_miso <= 1'b0;
      r_ss_n <= 1'b1;
      r_fin  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_fin  <= 1'b0;
      r_done <= r_fin;
      if (!r_busy) begin
        if (wrt) begin
          r_busy <= 1'b1;
          r_ss_n <= 1'b0;
          r_div  <= '0;
          r_bits <= '0;
          r_shft <= cmd;
        end
      end else begin
        r_div <= r_div + 1'b1;
        if (r_div == c_RISE) begin
          r_miso <= MISO;
          r_bits <= r_bits + 1'b1;
        end
        if (r_div == c_FALL && r_bits != 5'd0) begin
          r_shft <= {r_shft[14:0], r_miso};
          if (r_bits == 5'd16) begin
            r_busy <= 1'b0;
            r_ss_n <= 1'b1;
            r_fin  <= 1'b1;
          end
        end
      end
    end
  end

  assign SCLK  = ~(r_busy & r_div[DIV_W-1]);
  assign MOSI  = r_busy & r_shft[15];
  assign SS_n  = r_ss_n;
  assign rspns = r_shft;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: rtl/a2d_intf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | a2d_intf : round-robin ADC sequencer (ch 0,1,3,4); optional rounding |
// | average filter via macro A2D_FILT_EN.            Rev 1.0             |
// +----------------------------------------------------------------------+
module a2d_intf
  import a2d_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  localparam int CNT_W = FAST_SIM ? PERIOD_W_FAST : PERIOD_W;

  logic [CNT_W-1:0] r_period;
  a2d_state_t       r_state;
  logic [1:0]       r_idx;
  logic             r_wrt;
  logic [15:0]      r_cmd;
  logic             r_cnv;
  logic [11:0]      r_batt, r_curr, r_brake, r_torque;

  logic             w_start;
  logic             w_done;
  logic [15:0]      w_rspns;
  logic [11:0]      w_wval;
  logic [3:0]       w_unused_hi;

  assign w_start     = &r_period;
  assign w_unused_hi = w_rspns[15:12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_period <= '0;
    else     r_period <= r_period + 1'b1;
  end

`ifdef A2D_FILT_EN
  logic [3:0]  r_valid;
  logic [11:0] w_old;

  always_comb begin
    w_old = r_batt;
    case (r_idx)
      2'd0:    w_old = r_batt;
      2'd1:    w_old = r_curr;
      2'd2:    w_old = r_brake;
      default: w_old = r_torque;
    endcase
  end

  // First sample per channel after reset is taken raw to avoid averaging with 0.
  assign w_wval = r_valid[r_idx]
                ? 12'(({1'b0, w_old} + {1'b0, w_rspns[11:0]} + 13'd1) >> 1)
                : w_rspns[11:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_valid         <= '0;
    else if (r_state == UPDATE) r_valid[r_idx] <= 1'b1;
  end
`else
  assign w_wval = w_rspns[11:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_wrt    <= 1'b0;
      r_cmd    <= '0;
      r_cnv    <= 1'b0;
      r_batt   <= '0;
      r_curr   <= '0;
      r_brake  <= '0;
      r_torque <= '0;
    end else begin
      r_wrt <= 1'b0;
      r_cnv <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= XMIT1;
            r_wrt   <= 1'b1;
            r_cmd   <= {2'b00, idx2chnl(r_idx), 11'h000};
          end
        end
        XMIT1: if (w_done) r_state <= GAP;
        GAP: begin
          r_state <= XMIT2;
          r_wrt   <= 1'b1;
          r_cmd   <= 16'h0000;
        end
        XMIT2: if (w_done) r_state <= UPDATE;
        UPDATE: begin
          case (r_idx)
            2'd0:    r_batt   <= w_wval;
            2'd1:    r_curr   <= w_wval;
            2'd2:    r_brake  <= w_wval;
            default: r_torque <= w_wval;
          endcase
          r_cnv   <= 1'b1;
          r_idx   <= r_idx + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  spi_mnrch u_spi (
    .clk   (clk),
    .rst   (rst),
    .wrt   (r_wrt),
    .cmd   (r_cmd),
    .MISO  (MISO),
    .done  (w_done),
    .rspns (w_rspns),
    .SS_n  (SS_n),
    .SCLK  (SCLK),
    .MOSI  (MOSI)
  );

  assign batt      = r_batt;
  assign curr      = r_curr;
  assign brake     = r_brake;
  assign torque    = r_torque;
  assign cnv_cmplt = r_cnv;

endmodule
`default_nettype wire
